enc_round_sched: RTL
====================

Name: enc_round_sched

Overview:
- Controller that shares one 8-bit encryption round datapath between two requesters.
- Datapath stages: expansion, key XOR, 4-bit nibble add, concat.
- Arbitrates requesters round-robin, accepts one job at a time, iterates the round ROUNDS times with a rotating round key, and presents the result on a valid/ready output port tagged with the requester ID.
- Sits between producer blocks and the downstream consumer of encrypted bytes.

Parameters:
- ROUNDS, 4, number of round iterations per job; legal range 1..15.

Ports:
- clk  input  1  clock; all state changes on rising edge.
- reset  input  1  synchronous, active-high reset.
- req_valid  input  2  per-requester job valid; bit i = requester i.
- req_ready  output  2  per-requester accept; at most one bit high.
- req_number0  input  8  requester 0 plaintext.
- req_key0  input  8  requester 0 key.
- req_number1  input  8  requester 1 plaintext.
- req_key1  input  8  requester 1 key.
- out_valid  output  1  result valid.
- out_ready  input  1  consumer accept.
- out_data  output  8  encrypted byte.
- out_id  output  1  requester that issued the job.
- busy  output  1  high in any state other than IDLE.

Behaviour:
- Reset (synchronous, active-high, clock clk):
  - State goes to IDLE; state/key/ID registers and the round counter go to 0.
  - Outputs: req_ready=00, out_valid=0, out_data=0, out_id=0, busy=0.
  - last_grant=1, so requester 0 wins the first contention.
- Round function f(s,k), all widths exact:
  - exp bits 7..0 = {s[3],s[0],s[1],s[2],s[1],s[3],s[2],s[0]}.
  - x = exp ^ k.
  - sum = (x[7:4] + x[3:0] + k[0]) mod 16; the carry is discarded.
  - f = {sum, s[3:0]}.
- Key schedule: round r (0-based) uses the job key rotated left by r bits. The key register rotates left by 1 after each round.
- FSM states: IDLE, ROUND, DONE.
- IDLE:
  - Grant = the only valid requester. If both are valid, grant the requester != last_grant.
  - req_ready[grant]=1 combinationally, only in IDLE, independent of out_ready.
  - On an edge with a valid grant: latch number/key/ID, cnt=0, last_grant=grant, go to ROUND.
- ROUND:
  - Each edge: s<=f(s,k), k<=rotl(k,1), cnt++.
  - On the edge where cnt==ROUNDS-1: go to DONE.
- DONE:
  - out_valid=1; out_data and out_id held stable.
  - On an edge with out_ready=1: go to IDLE; out_valid drops in the next cycle.
- Latency: accept at edge E0; out_valid is high in the cycle after edge E_ROUNDS, i.e. ROUNDS+1 edges after acceptance.
- Throughput: one job per ROUNDS+2 cycles with out_ready held high. No overlap: req_ready stays 00 in ROUND and DONE.
- Requester contract: number/key are stable while req_valid & !req_ready. The controller samples them only on the accept edge.
- Backpressure: out_ready low holds DONE indefinitely. New requests wait; they are not dropped.
- out_valid is never withdrawn without a handshake, except by reset.
- A request that deasserts before being granted is simply not accepted; no error.
- Reset mid-operation: the job is aborted with no output; the first edge after reset release may accept a new job.
- out_data is 0 outside DONE.

Test Plan:
- ROUNDS=1, req0 number=0100_0110, key=1001_0011 -> out_data=0100_0110, out_id=0, out_valid two edges after accept.
- ROUNDS=4, req0 number=0100_0110, key=1001_0011 -> out_data=0000_0110, out_id=0, out_valid five edges after accept, busy high throughout.
- ROUNDS=4, req_valid=11 held with different jobs:
  - req0 is granted first; req1 is granted next.
  - req1 number=1100_1001, key=1010_1100 -> out_data=1011_1001, out_id=1.
  - Grants keep alternating 0,1,0,1.
- out_ready held low 10 cycles in DONE -> out_valid and out_data stable, req_ready=00. On out_ready=1, the next job is accepted one cycle after out_valid falls.
- reset=1 for one cycle during ROUND (cnt=2) -> all outputs 0, no out_valid for the aborted job. A pending request is accepted on the first edge after release.
- Random req_valid over 500 jobs vs. reference model:
  - at most one req_ready bit, and only in IDLE;
  - no lost or duplicated job;
  - results and IDs match.

Source files
------------

// File: rtl/enc_round_sched.sv
// rtl/enc_round_sched.sv - two-requester round-robin scheduler around a shared 8-bit encryption round
//
// Purpose:
//   Shares one 8-bit round datapath (expansion, key XOR, nibble add, concat)
//   between two requesters. One job is in flight at a time. Each job runs
//   ROUNDS iterations with a key that rotates left by one bit per round. The
//   result is offered on a valid/ready port, tagged with the requester ID.
//
// Ports:
//   clk          clock, all state changes on the rising edge
//   reset        synchronous, active-high reset
//   req_valid    per-requester job valid (bit i = requester i)
//   req_ready    per-requester accept, at most one bit high, only in IDLE
//   req_number0  requester 0 plaintext
//   req_key0     requester 0 key
//   req_number1  requester 1 plaintext
//   req_key1     requester 1 key
//   out_valid    result valid (DONE state)
//   out_ready    consumer accept
//   out_data     encrypted byte, 0 outside DONE
//   out_id       requester that issued the job, 0 outside DONE
//   busy         high whenever the controller is not IDLE

module enc_round_sched #(
  parameter int ROUNDS = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] req_valid,
  output logic [1:0] req_ready,
  input  logic [7:0] req_number0,
  input  logic [7:0] req_key0,
  input  logic [7:0] req_number1,
  input  logic [7:0] req_key1,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [7:0] out_data,
  output logic       out_id,
  output logic       busy
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ROUND = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam logic [3:0] LAST_CNT = 4'(ROUNDS - 1);

  state_t     state_q, state_d;
  logic [7:0] s_q, s_d;
  logic [7:0] k_q, k_d;
  logic       id_q, id_d;
  logic [3:0] cnt_q, cnt_d;
  logic       last_grant_q, last_grant_d;

  logic       grant_valid;
  logic       grant;

  // One round: bit-permuting expansion of the low nibble, XOR with the key,
  // add the two nibbles plus key bit 0 (carry dropped), keep the low nibble.
  function automatic logic [7:0] round_f(input logic [7:0] s, input logic [7:0] k);
    logic [7:0] expd;
    logic [7:0] x;
    logic [3:0] sum;
    expd = {s[3], s[0], s[1], s[2], s[1], s[3], s[2], s[0]};
    x    = expd ^ k;
    sum  = x[7:4] + x[3:0] + {3'b000, k[0]};
    return {sum, s[3:0]};
  endfunction

  // Round-robin: a lone requester always wins; on contention the one that
  // did not win last time gets the slot.
  always_comb begin
    grant_valid = |req_valid;
    case (req_valid)
      2'b01:   grant = 1'b0;
      2'b10:   grant = 1'b1;
      2'b11:   grant = ~last_grant_q;
      default: grant = 1'b0;
    endcase
  end

  always_comb begin
    state_d      = state_q;
    s_d          = s_q;
    k_d          = k_q;
    id_d         = id_q;
    cnt_d        = cnt_q;
    last_grant_d = last_grant_q;
    req_ready    = 2'b00;
    out_valid    = 1'b0;
    out_data     = 8'h00;
    out_id       = 1'b0;
    busy         = (state_q != IDLE);

    case (state_q)
      IDLE: begin
        if (grant_valid) begin
          // Gated by reset so no requester sees an accept that reset will void.
          if (!reset) begin
            req_ready = grant ? 2'b10 : 2'b01;
          end
          s_d          = grant ? req_number1 : req_number0;
          k_d          = grant ? req_key1 : req_key0;
          id_d         = grant;
          cnt_d        = 4'd0;
          last_grant_d = grant;
          state_d      = ROUND;
        end
      end

      ROUND: begin
        s_d   = round_f(s_q, k_q);
        k_d   = {k_q[6:0], k_q[7]};
        cnt_d = cnt_q + 4'd1;
        if (cnt_q == LAST_CNT) begin
          state_d = DONE;
        end
      end

      DONE: begin
        out_valid = 1'b1;
        out_data  = s_q;
        out_id    = id_q;
        if (out_ready) begin
          state_d = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      s_q          <= 8'h00;
      k_q          <= 8'h00;
      id_q         <= 1'b0;
      cnt_q        <= 4'd0;
      last_grant_q <= 1'b1;
    end else begin
      state_q      <= state_d;
      s_q          <= s_d;
      k_q          <= k_d;
      id_q         <= id_d;
      cnt_q        <= cnt_d;
      last_grant_q <= last_grant_d;
    end
  end

endmodule
